// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel-rate prescaler, horizontal/vertical counters, registered
// sync/blank/coordinate outputs, and frame / frame-group strobes.
module vga_sync_gen #(
  parameter int   CLK_DIV   = 2,
  parameter int   H_VIS     = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_VIS     = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic SYNC_POL  = 1'b0,
  parameter int   FRAME_DIV = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  output logic [9:0] pixelX,
  output logic [9:0] pixelY,
  output logic       hSync,
  output logic       vSync,
  output logic       videoOn,
  output logic       frameTick,
  output logic       stepTick
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_DIV - 1);
  localparam logic [9:0]    H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]    HS_FIRST   = 10'(H_VIS + H_FP);
  localparam logic [9:0]    HS_LAST    = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0]    VS_FIRST   = 10'(V_VIS + V_FP);
  localparam logic [9:0]    VS_LAST    = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0]    H_VIS_L    = 10'(H_VIS);
  localparam logic [9:0]    V_VIS_L    = 10'(V_VIS);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_next;
  logic [FW-1:0] frame_cnt;
  logic [9:0]    h_next;
  logic [9:0]    v_next;
  logic          pix_tick;
  logic          wrap;

  function automatic logic sync_dec(input logic [9:0] c, input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (c >= lo && c <= hi) ? SYNC_POL : ~SYNC_POL;
  endfunction

  function automatic logic video_dec(input logic [9:0] h, input logic [9:0] v);
    return (h < H_VIS_L) && (v < V_VIS_L);
  endfunction

  // Next-state counts; pixelX/pixelY are the count registers themselves.
  always_comb begin
    pix_tick = (div_cnt == DIV_LAST);
    div_next = div_cnt;
    h_next   = pixelX;
    v_next   = pixelY;
    wrap     = 1'b0;
    if (enable) begin
      div_next = pix_tick ? '0 : div_cnt + 1'b1;
      if (pix_tick) begin
        if (pixelX == H_LAST) begin
          h_next = '0;
          if (pixelY == V_LAST) begin
            v_next = '0;
            wrap   = 1'b1;
          end else begin
            v_next = pixelY + 10'd1;
          end
        end else begin
          h_next = pixelX + 10'd1;
        end
      end
    end
  end

  // Outputs decoded from next-state counts so all of them describe the same pixel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      frame_cnt <= '0;
      pixelX    <= '0;
      pixelY    <= '0;
      hSync     <= ~SYNC_POL;
      vSync     <= ~SYNC_POL;
      videoOn   <= 1'b1;
      frameTick <= 1'b0;
      stepTick  <= 1'b0;
    end else begin
      div_cnt   <= div_next;
      pixelX    <= h_next;
      pixelY    <= v_next;
      hSync     <= sync_dec(h_next, HS_FIRST, HS_LAST);
      vSync     <= sync_dec(v_next, VS_FIRST, VS_LAST);
      videoOn   <= video_dec(h_next, v_next);
      frameTick <= wrap;
      stepTick  <= wrap && (frame_cnt == FRAME_LAST);
      if (wrap) begin
        frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two small-raster instances (CLK_DIV=2/active-low sync and
// CLK_DIV=1/active-high sync) compared every cycle against an elapsed-time model.
module tb_vga_sync_gen;

  localparam int HV = 20, HF = 3, HSY = 5, HB = 4;
  localparam int VV = 10, VF = 2, VSY = 2, VB = 3;
  localparam int HT = HV + HF + HSY + HB;   // 32
  localparam int VT = VV + VF + VSY + VB;   // 17
  localparam int FDIV = 4;
  localparam int DIV_A = 2, DIV_B = 1;
  localparam longint FA = longint'(DIV_A) * HT * VT;  // clocks per frame, instance A
  localparam longint FB = longint'(DIV_B) * HT * VT;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;

  logic [9:0] pxA, pyA, pxB, pyB;
  logic hsA, vsA, voA, ftA, stA;
  logic hsB, vsB, voB, ftB, stB;

  int checks = 0;
  int failures = 0;

  // Model state: enabled clock edges since reset, plus strobe expectations.
  longint na = 0, nb = 0;
  logic   eftA = 1'b0, estA = 1'b0, eftB = 1'b0, estB = 1'b0;

  always #5 clock = ~clock;

  vga_sync_gen #(
    .CLK_DIV(DIV_A), .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .SYNC_POL(1'b0), .FRAME_DIV(FDIV)
  ) dut_a (
    .clock(clock), .reset(reset), .enable(enable),
    .pixelX(pxA), .pixelY(pyA), .hSync(hsA), .vSync(vsA), .videoOn(voA),
    .frameTick(ftA), .stepTick(stA)
  );

  vga_sync_gen #(
    .CLK_DIV(DIV_B), .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .SYNC_POL(1'b1), .FRAME_DIV(FDIV)
  ) dut_b (
    .clock(clock), .reset(reset), .enable(enable),
    .pixelX(pxB), .pixelY(pyB), .hSync(hsB), .vSync(vsB), .videoOn(voB),
    .frameTick(ftB), .stepTick(stB)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ex_x(input longint n, input int div);
    return int'((n / longint'(div)) % longint'(HT));
  endfunction

  function automatic int ex_y(input longint n, input int div);
    return int'((n / (longint'(div) * HT)) % longint'(VT));
  endfunction

  function automatic logic ex_sync(input int c, input int lo, input int len, input logic pol);
    return (c >= lo && c < lo + len) ? pol : ~pol;
  endfunction

  task automatic check_all();
    int xa, ya, xb, yb;
    xa = ex_x(na, DIV_A); ya = ex_y(na, DIV_A);
    xb = ex_x(nb, DIV_B); yb = ex_y(nb, DIV_B);
    chk("a_pixelX", 32'(pxA), 32'(xa));
    chk("a_pixelY", 32'(pyA), 32'(ya));
    chk("a_hSync", 32'(hsA), 32'(ex_sync(xa, HV + HF, HSY, 1'b0)));
    chk("a_vSync", 32'(vsA), 32'(ex_sync(ya, VV + VF, VSY, 1'b0)));
    chk("a_videoOn", 32'(voA), 32'(xa < HV && ya < VV));
    chk("a_frameTick", 32'(ftA), 32'(eftA));
    chk("a_stepTick", 32'(stA), 32'(estA));
    chk("b_pixelX", 32'(pxB), 32'(xb));
    chk("b_pixelY", 32'(pyB), 32'(yb));
    chk("b_hSync", 32'(hsB), 32'(ex_sync(xb, HV + HF, HSY, 1'b1)));
    chk("b_vSync", 32'(vsB), 32'(ex_sync(yb, VV + VF, VSY, 1'b1)));
    chk("b_videoOn", 32'(voB), 32'(xb < HV && yb < VV));
    chk("b_frameTick", 32'(ftB), 32'(eftB));
    chk("b_stepTick", 32'(stB), 32'(estB));
  endtask

  // One clock edge with the given enable; model advances, then outputs are sampled mid-cycle.
  task automatic tick(input logic en);
    enable = en;
    @(posedge clock);
    if (reset) begin
      na = 0; nb = 0; eftA = 0; estA = 0; eftB = 0; estB = 0;
    end else if (en) begin
      na++; nb++;
      eftA = (na % FA == 0);
      estA = eftA && ((na / FA) % FDIV == 0);
      eftB = (nb % FB == 0);
      estB = eftB && ((nb / FB) % FDIV == 0);
    end else begin
      eftA = 0; estA = 0; eftB = 0; estB = 0;
    end
    @(negedge clock);
    check_all();
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b1;
    na = 0; nb = 0; eftA = 0; estA = 0; eftB = 0; estB = 0;
    #1;
    check_all();
    chk("rst_a_hSync_high", 32'(hsA), 32'd1);
    chk("rst_a_vSync_high", 32'(vsA), 32'd1);
    tick(1'b1);
    reset = 1'b0;
  endtask

  initial begin
    int ftcnt, stcnt;
    logic [2:0] lvl;
    logic [9:0] held_x;
    logic held_hs;

    // Reset state
    @(negedge clock);
    check_all();
    chk("reset_videoOn", 32'(voA), 32'd1);
    reset = 1'b0;

    // One full frame plus a line of free running
    for (int i = 0; i < int'(FA) + DIV_A * HT; i++) tick(1'b1);

    // Freeze for 37 clocks at pixelX = 10
    for (int i = 0; i < 200 && pxA != 10'd10; i++) tick(1'b1);
    chk("reach_x10", 32'(pxA), 32'd10);
    held_x = pxA; held_hs = hsA;
    for (int i = 0; i < 37; i++) tick(1'b0);
    chk("freeze_hold_x", 32'(pxA), 32'(held_x));
    chk("freeze_hold_hs", 32'(hsA), 32'(held_hs));
    for (int i = 0; i < int'(FA); i++) tick(1'b1);

    // Enable dropped on the cycle a wrap would occur
    for (int i = 0; i < int'(FA) + 4 && !(ex_x(na + 1, DIV_A) == 0 && ex_y(na + 1, DIV_A) == 0
         && (na + 1) % DIV_A == 0); i++) tick(1'b1);
    for (int i = 0; i < 5; i++) tick(1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1);

    // Randomized enable pattern
    for (int i = 0; i < 4000; i++) tick($urandom_range(0, 3) != 0);

    // Async reset mid-frame, between edges
    async_reset();

    // Ten frames: count strobes and feed a 3-bit level counter
    ftcnt = 0; stcnt = 0; lvl = 3'd0;
    for (int i = 0; i < 10 * int'(FA); i++) begin
      tick(1'b1);
      if (ftA === 1'b1) ftcnt++;
      if (stA === 1'b1) begin
        stcnt++;
        lvl = lvl + 3'd1;
      end
    end
    chk("frame_count", 32'(ftcnt), 32'd10);
    chk("step_count", 32'(stcnt), 32'd2);
    chk("level_counter", 32'(lvl), 32'd2);

    // Reset again partway into a frame; no pulse from the partial frame
    for (int i = 0; i < 300; i++) tick(1'b1);
    async_reset();
    for (int i = 0; i < 50; i++) tick(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Pixel timing generator for the VGA controller. It divides the system clock down to the pixel rate and runs the horizontal and vertical raster counters. It produces the sync, blanking and pixel-coordinate signals for the colour path, plus a frame-rate `stepTick` that drives the `enable` input of the 3-bit up/down level counter directly downstream. The default timing is 640x480@60 from a 50 MHz clock.

## Interface
- `CLK_DIV`, 2: system clocks per pixel (>=1).
- `H_VIS`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48: horizontal pixels. Visible, front porch, sync, back porch.
- `V_VIS`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33: vertical lines. Same order.
- `SYNC_POL`, 0: active level of `hSync`/`vSync`. Inactive level = `~SYNC_POL`.
- `FRAME_DIV`, 4: frames per `stepTick` (1..256).
- `clock` in 1: system clock. All state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: run/freeze.
- `pixelX` out 10: current column, 0..H_TOTAL-1.
- `pixelY` out 10: current line, 0..V_TOTAL-1.
- `hSync` out 1: horizontal sync.
- `vSync` out 1: vertical sync.
- `videoOn` out 1: high when (`pixelX`,`pixelY`) is in the visible area.
- `frameTick` out 1: one-clock pulse at the start of each frame.
- `stepTick` out 1: one-clock pulse every `FRAME_DIV` frames. Goes to the level counter's `enable`.

## Operation
- Derived totals: H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525). Both must be <= 1024.
- Prescaler `divCnt` counts 0..CLK_DIV-1 and wraps. `pixTick` is high when `divCnt == CLK_DIV-1`. With CLK_DIV=1, `pixTick` is always high.
- On `pixTick`:
  - `hCount` increments.
  - At H_TOTAL-1 it wraps to 0, and `vCount` increments.
  - At V_TOTAL-1, `vCount` wraps to 0.
- Decode, as a function of the count values:
  - `hSync` active for `hCount` in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1], i.e. 656..751.
  - `vSync` active for `vCount` in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1], i.e. 490..491.
  - `videoOn` = (`hCount` < H_VIS) && (`vCount` < V_VIS).
- All outputs are registered. `pixelX`, `pixelY`, `hSync`, `vSync` and `videoOn` update on the same edge and always describe the same pixel. They are decoded from the next-state counts, so no output is combinational.
- Frame counter `frameCnt` runs 0..FRAME_DIV-1.
  - On the wrap (799,524) -> (0,0), `frameTick` goes high for exactly one `clock` cycle, not for a whole pixel period, and `frameCnt` advances.
  - `stepTick` goes high in the same cycle as `frameTick` when `frameCnt` wraps from FRAME_DIV-1 to 0.
- `enable` low:
  - `divCnt`, the counters and `frameCnt` all hold.
  - `frameTick` and `stepTick` are forced to 0.
  - Sync and video outputs hold their last values.
  - Operation resumes on the first edge with `enable` high, with no lost or duplicated pixel.
- Reset values:
  - `divCnt`, `hCount`, `vCount`, `frameCnt` = 0.
  - `pixelX` = 0, `pixelY` = 0, `videoOn` = 1.
  - `hSync` = `vSync` = `~SYNC_POL`.
  - `frameTick` = `stepTick` = 0.
  - No frame pulse is generated on reset exit.

## Timing
- One pixel lasts CLK_DIV clocks. With the defaults, one line is 1600 clocks and one frame is 840000 clocks.
- The first `frameTick` after reset release is high in the clock cycle following the 840000th rising edge, which is the edge that wraps the counts to (0,0).
- `stepTick` occurs on every FRAME_DIV-th `frameTick` (the 4th, 8th, …) and never on any other cycle.
- Reset asserted mid-frame: all state clears immediately, without waiting for a clock. A partially completed frame produces no pulse.
- `enable` deasserted on the cycle a wrap would occur: the wrap and its `frameTick` are deferred to the first enabled `pixTick` edge.

## Test plan
- Line timing, defaults: reset, then run 1600 clocks.
  - `pixelX` steps every 2 clocks over 0..799 and returns to 0.
  - `hSync` is 0 exactly while `pixelX` = 656..751 (192 clocks).
  - `videoOn` falls when `pixelX` goes 639 -> 640.
  - `pixelY` = 1 after the wrap.
- Frame timing: run 840000 clocks.
  - `vSync` is 0 only for `pixelY` 490..491 (3200 clocks).
  - Exactly one `frameTick` occurs, high for 1 clock, coinciding with `pixelX` = `pixelY` = 0.
- Step divider, FRAME_DIV=4: run 10 frames.
  - `frameTick` count = 10.
  - `stepTick` fires only with frames 4 and 8.
  - A downstream 3-bit counter receiving these pulses reads 2.
- Enable freeze: drop `enable` for 37 clocks at `pixelX` = 100.
  - All outputs hold.
  - After re-enable, `pixelX` continues 100 -> 101 after 2 clocks.
  - The frame length grows by exactly 37 clocks.
- Async reset mid-frame: assert `reset` at (300,200) between clock edges.
  - Outputs immediately show `pixelX`=0, `pixelY`=0, `videoOn`=1, `hSync`=`vSync`=1.
  - No `frameTick` or `stepTick` occurs.
- CLK_DIV=1, SYNC_POL=1: `pixelX` increments every clock, and `hSync` is high for exactly 96 clocks per 800-clock line.
